// File: rtl/dmem_bus_ctrl.sv
// Data-side bus controller: decodes EX_DM accesses to internal DM, NUM_CH
// req/ack channels or unmapped space. Define DMEM_BUS_TIMEOUT_EN for the BUSY timeout.
module dmem_bus_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int NUM_CH      = 4,
  parameter int SEL_LSB     = 12,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        cpu_addr,
  input  logic [DATA_W-1:0]        cpu_wdata,
  input  logic                     cpu_re,
  input  logic                     cpu_we,
  output logic [DATA_W-1:0]        cpu_rdata,
  output logic                     cpu_stall,
  output logic                     cpu_err,
  output logic                     dm_re,
  output logic                     dm_we,
  output logic [NUM_CH-1:0]        ext_sel,
  output logic [ADDR_W-1:0]        ext_addr,
  output logic [DATA_W-1:0]        ext_wdata,
  output logic                     ext_re,
  output logic                     ext_we,
  input  logic [NUM_CH*DATA_W-1:0] ext_rdata,
  input  logic [NUM_CH-1:0]        ext_ack
);

  localparam int RW   = ADDR_W - SEL_LSB;
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
`ifdef DMEM_BUS_TIMEOUT_EN
  localparam logic [1:0] ERR  = 2'd3;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
`endif

  logic [1:0]        state_reg, state_next;
  logic [CH_W-1:0]   ch_reg;
  logic              op_we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] hold_reg;

  logic [RW-1:0]     region;
  logic              access, is_int, is_ext, start, busy;
  logic [NUM_CH-1:0] ch_dec;
  logic              ack_hit;
  logic [DATA_W-1:0] ack_rdata;

  assign region = cpu_addr[ADDR_W-1:SEL_LSB];
  assign access = cpu_re | cpu_we;
  assign is_int = (region == '0);
  assign is_ext = (region != '0) && (int'(region) <= NUM_CH);
  assign busy   = (state_reg == BUSY);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_dec[gi]  = (ch_reg == CH_W'(gi));
      assign ext_sel[gi] = busy & ch_dec[gi];
    end
  endgenerate

  // Only the registered channel's ack and data are ever looked at.
  assign ack_hit = |(ext_ack & ch_dec);

  always_comb begin
    ack_rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_dec[i]) ack_rdata = ack_rdata | ext_rdata[i*DATA_W +: DATA_W];
    end
  end

  assign ext_re    = busy & ~op_we_reg;
  assign ext_we    = busy & op_we_reg;
  assign ext_addr  = addr_reg;
  assign ext_wdata = wdata_reg;

`ifdef DMEM_BUS_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt_reg;
  logic             timeout_hit;

  assign timeout_hit = (wait_cnt_reg == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_reg <= '0;
    end else if (start) begin
      wait_cnt_reg <= '0;
    end else if (busy && !ack_hit) begin
      wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
    end
  end
`endif

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    cpu_stall  = 1'b0;
    cpu_err    = 1'b0;
    dm_re      = 1'b0;
    dm_we      = 1'b0;
    cpu_rdata  = hold_reg;
    case (state_reg)
      IDLE: begin
        if (access) begin
          // Simultaneous load and store is executed as a store but flagged.
          if (cpu_re & cpu_we) cpu_err = 1'b1;
          if (is_int) begin
            dm_re = cpu_re & ~cpu_we;
            dm_we = cpu_we;
          end else if (is_ext) begin
            cpu_stall  = 1'b1;
            start      = 1'b1;
            state_next = BUSY;
          end else begin
            cpu_err   = 1'b1;
            cpu_rdata = '0;
          end
        end
      end
      BUSY: begin
        cpu_stall = 1'b1;
        if (ack_hit) begin
          state_next = DONE;
`ifdef DMEM_BUS_TIMEOUT_EN
        end else if (timeout_hit) begin
          state_next = ERR;
`endif
        end
      end
      // The request still on cpu_* is the one just completed; never restart it.
      DONE: state_next = IDLE;
`ifdef DMEM_BUS_TIMEOUT_EN
      ERR: begin
        cpu_err    = 1'b1;
        cpu_rdata  = '1;
        state_next = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ch_reg    <= '0;
      op_we_reg <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (start) begin
        ch_reg    <= CH_W'(region - RW'(1));
        op_we_reg <= cpu_we;
        addr_reg  <= cpu_addr;
        wdata_reg <= cpu_wdata;
      end
      if (busy && ack_hit && !op_we_reg) hold_reg <= ack_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Scoreboard bench for dmem_bus_ctrl: drivers queue expected completions,
// a negedge monitor pops and compares each one the DUT presents.
module tb_dmem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_re;
  logic        cpu_we;
  logic [15:0] cpu_rdata;
  logic        cpu_stall;
  logic        cpu_err;
  logic        dm_re;
  logic        dm_we;
  logic [3:0]  ext_sel;
  logic [15:0] ext_addr;
  logic [15:0] ext_wdata;
  logic        ext_re;
  logic        ext_we;
  logic [63:0] ext_rdata;
  logic [3:0]  ext_ack;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] rdata;
    logic        err;
    logic        dre;
    logic        dwe;
    logic [31:0] stalls;
    logic [3:0]  sel;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        re;
    logic        we;
  } exp_t;

  exp_t exp_q[$];

  dmem_bus_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_re    (cpu_re),
    .cpu_we    (cpu_we),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .cpu_err   (cpu_err),
    .dm_re     (dm_re),
    .dm_we     (dm_we),
    .ext_sel   (ext_sel),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .ext_re    (ext_re),
    .ext_we    (ext_we),
    .ext_rdata (ext_rdata),
    .ext_ack   (ext_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] rdata, input logic err, input logic dre,
                              input logic dwe, input int stalls, input logic [3:0] sel,
                              input logic [15:0] addr, input logic [15:0] wdata,
                              input logic re, input logic we);
    exp_t e;
    e.rdata = rdata; e.err = err; e.dre = dre; e.dwe = dwe; e.stalls = 32'(stalls);
    e.sel = sel; e.addr = addr; e.wdata = wdata; e.re = re; e.we = we;
    return e;
  endfunction

  // Monitor: a completion is any cycle with a request present and no stall.
  initial begin
    int          stall_cnt;
    logic [3:0]  s_sel;
    logic [15:0] s_addr, s_wdata;
    logic        s_re, s_we;
    exp_t        e;
    stall_cnt = 0; s_sel = '0; s_addr = '0; s_wdata = '0; s_re = 1'b0; s_we = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_cnt = 0; s_sel = '0; s_addr = '0; s_wdata = '0; s_re = 1'b0; s_we = 1'b0;
      end else if (cpu_re | cpu_we) begin
        if (cpu_stall) begin
          stall_cnt++;
          if (ext_sel != '0) begin
            s_sel = ext_sel; s_addr = ext_addr; s_wdata = ext_wdata; s_re = ext_re; s_we = ext_we;
          end
        end else begin
          $display("txn addr=%h re=%b we=%b rdata=%h err=%b stalls=%0d sel=%b",
                   cpu_addr, cpu_re, cpu_we, cpu_rdata, cpu_err, stall_cnt, s_sel);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_completion: got addr %h expected none", cpu_addr);
          end else begin
            e = exp_q.pop_front();
            chk("rdata",     32'(cpu_rdata), 32'(e.rdata));
            chk("err",       32'(cpu_err),   32'(e.err));
            chk("dm_re",     32'(dm_re),     32'(e.dre));
            chk("dm_we",     32'(dm_we),     32'(e.dwe));
            chk("stalls",    32'(stall_cnt), e.stalls);
            chk("ext_sel",   32'(s_sel),     32'(e.sel));
            chk("ext_addr",  32'(s_addr),    32'(e.addr));
            chk("ext_wdata", 32'(s_wdata),   32'(e.wdata));
            chk("ext_re",    32'(s_re),      32'(e.re));
            chk("ext_we",    32'(s_we),      32'(e.we));
          end
          stall_cnt = 0; s_sel = '0; s_addr = '0; s_wdata = '0; s_re = 1'b0; s_we = 1'b0;
        end
      end
    end
  end

  task automatic single(input logic [15:0] addr, input logic [15:0] wdata,
                        input logic re, input logic we, input exp_t e);
    exp_q.push_back(e);
    @(posedge clk); #1;
    cpu_addr = addr; cpu_wdata = wdata; cpu_re = re; cpu_we = we;
    @(posedge clk); #1;
    cpu_re = 1'b0; cpu_we = 1'b0;
  endtask

  // Ack arrives in the n-th BUSY cycle; stray acks are held until then.
  task automatic ext_txn(input logic [15:0] addr, input logic [15:0] wdata,
                         input logic re, input logic we, input int ch, input int n,
                         input logic [15:0] rd, input logic [3:0] stray, input exp_t e);
    exp_q.push_back(e);
    @(posedge clk); #1;
    cpu_addr = addr; cpu_wdata = wdata; cpu_re = re; cpu_we = we; ext_ack = stray;
    repeat (n) begin @(posedge clk); #1; end
    ext_ack = '0;
    ext_ack[ch] = 1'b1;
    ext_rdata[ch*16 +: 16] = rd;
    @(posedge clk); #1;
    ext_ack = '0;
    @(posedge clk); #1;
    cpu_re = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    chk("no_restart_sel",   32'(ext_sel),   32'h0);
    chk("no_restart_stall", 32'(cpu_stall), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_re = 1'b0; cpu_we = 1'b0;
    ext_ack = '0; ext_rdata = 64'h1111_2222_3333_4444;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_stall",     32'(cpu_stall), 32'h0);
    chk("rst_err",       32'(cpu_err),   32'h0);
    chk("rst_sel",       32'(ext_sel),   32'h0);
    chk("rst_ext_re",    32'(ext_re),    32'h0);
    chk("rst_ext_we",    32'(ext_we),    32'h0);
    chk("rst_rdata",     32'(cpu_rdata), 32'h0);
    chk("rst_ext_addr",  32'(ext_addr),  32'h0);
    chk("rst_ext_wdata", 32'(ext_wdata), 32'h0);

    single(16'h0040, 16'h1234, 1'b0, 1'b1, mk(16'h0000, 0, 0, 1, 0, 4'h0, 16'h0, 16'h0, 0, 0));
    single(16'h0100, 16'h0000, 1'b1, 1'b0, mk(16'h0000, 0, 1, 0, 0, 4'h0, 16'h0, 16'h0, 0, 0));
    ext_txn(16'h1008, 16'h5555, 1'b1, 1'b0, 0, 3, 16'hBEEF, 4'b0100,
            mk(16'hBEEF, 0, 0, 0, 4, 4'b0001, 16'h1008, 16'h5555, 1, 0));
    single(16'h0200, 16'h0000, 1'b1, 1'b0, mk(16'hBEEF, 0, 1, 0, 0, 4'h0, 16'h0, 16'h0, 0, 0));
    ext_txn(16'h4010, 16'h00A5, 1'b0, 1'b1, 3, 1, 16'h7777, 4'b0010,
            mk(16'hBEEF, 0, 0, 0, 2, 4'b1000, 16'h4010, 16'h00A5, 0, 1));
    single(16'hF000, 16'h0000, 1'b1, 1'b0, mk(16'h0000, 1, 0, 0, 0, 4'h0, 16'h0, 16'h0, 0, 0));
    single(16'h0300, 16'h0000, 1'b1, 1'b0, mk(16'hBEEF, 0, 1, 0, 0, 4'h0, 16'h0, 16'h0, 0, 0));
    single(16'h0050, 16'h9999, 1'b1, 1'b1, mk(16'hBEEF, 1, 0, 1, 0, 4'h0, 16'h0, 16'h0, 0, 0));
    single(16'h5000, 16'h4321, 1'b0, 1'b1, mk(16'h0000, 1, 0, 0, 0, 4'h0, 16'h0, 16'h0, 0, 0));
    ext_txn(16'h2002, 16'h0000, 1'b1, 1'b0, 1, 2, 16'h0C0D, 4'b0000,
            mk(16'h0C0D, 0, 0, 0, 3, 4'b0010, 16'h2002, 16'h0000, 1, 0));

    // Reset lands in the second BUSY cycle of a channel-1 load.
    @(posedge clk); #1;
    cpu_addr = 16'h2000; cpu_wdata = 16'h0000; cpu_re = 1'b1; cpu_we = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; cpu_re = 1'b0;
    @(negedge clk);
    chk("abort_ext_re",   32'(ext_re),    32'h0);
    chk("abort_sel",      32'(ext_sel),   32'h0);
    chk("abort_stall",    32'(cpu_stall), 32'h0);
    chk("abort_err",      32'(cpu_err),   32'h0);
    chk("abort_rdata",    32'(cpu_rdata), 32'h0);
    chk("abort_ext_addr", 32'(ext_addr),  32'h0);

`ifdef DMEM_BUS_TIMEOUT_EN
    exp_q.push_back(mk(16'hFFFF, 1, 0, 0, 16, 4'b0100, 16'h3000, 16'h0000, 1, 0));
    @(posedge clk); #1;
    cpu_addr = 16'h3000; cpu_wdata = 16'h0000; cpu_re = 1'b1; cpu_we = 1'b0;
    repeat (17) begin @(posedge clk); #1; end
    cpu_re = 1'b0;
`else
    begin
      int high;
      high = 0;
      @(posedge clk); #1;
      cpu_addr = 16'h3000; cpu_wdata = 16'h0000; cpu_re = 1'b1; cpu_we = 1'b0;
      repeat (100) begin
        @(negedge clk);
        if (cpu_stall) high++;
      end
      chk("no_timeout_stall_cycles", 32'(high), 32'd100);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; cpu_re = 1'b0;
    end
`endif

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_bus_ctrl.md
Name: dmem_bus_ctrl

Overview:
- Data-side memory bus controller that sits between the pipeline's EX_DM memory stage and the memory system.
- Generalises the fixed internal/external address split into a parametrised decode over 1 internal data memory plus NUM_CH external channels.
- External channels use a req/ack handshake with variable wait states; the controller stalls the pipeline until the access completes.
- Optional timeout turns a hung access into a bus error.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- NUM_CH, 4, number of external channels (1..14).
- SEL_LSB, 12, lowest address bit of the region field.
- TIMEOUT_CYC, 15, maximum wait cycles in BUSY before error (only with the timeout feature).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cpu_addr  in  ADDR_W  EX_DM effective address.
- cpu_wdata  in  DATA_W  store data.
- cpu_re  in  1  load request.
- cpu_we  in  1  store request.
- cpu_rdata  out  DATA_W  load data from the external channel.
- cpu_stall  out  1  hold all pipeline stages.
- cpu_err  out  1  one-cycle bus error pulse.
- dm_re  out  1  internal DM read enable.
- dm_we  out  1  internal DM write enable.
- ext_sel  out  NUM_CH  one-hot channel select.
- ext_addr  out  ADDR_W  registered address.
- ext_wdata  out  DATA_W  registered store data.
- ext_re  out  1  external read strobe.
- ext_we  out  1  external write strobe.
- ext_rdata  in  NUM_CH*DATA_W  channel read data; channel i occupies [i*DATA_W +: DATA_W].
- ext_ack  in  NUM_CH  per-channel completion.

Behaviour:
- Region decode: region = cpu_addr[ADDR_W-1:SEL_LSB].
  - region 0: internal DM.
  - region 1..NUM_CH: external channel region-1.
  - Any other region: unmapped.
- Access = cpu_re|cpu_we. If both are high, treat as a store and pulse cpu_err.
- Internal DM access (combinational, no stall): dm_re=cpu_re&~cpu_we, dm_we=cpu_we. Both are 0 for every other region and while state!=IDLE.
- Unmapped access:
  - cpu_err pulses for one cycle and there is no stall.
  - Stores are dropped.
  - cpu_rdata={DATA_W{1'b0}}.
- FSM states: IDLE, BUSY, DONE (plus ERR with the optional feature).
- IDLE:
  - External access: cpu_stall=1 combinationally. Register addr, wdata, op (write wins) and channel index. Next state BUSY.
  - Otherwise remain in IDLE.
- BUSY:
  - ext_sel one-hot from the registered channel; ext_re/ext_we from the registered op; ext_addr/ext_wdata held; cpu_stall=1.
  - On ext_ack[ch]: capture ext_rdata slice into the hold register (loads only) and go to DONE.
  - Acks on unselected channels are ignored.
- DONE:
  - All ext_* strobes and ext_sel are 0; cpu_stall=0; cpu_rdata=hold register.
  - The request still present on cpu_* is the completed one and must NOT start a new transaction.
  - Next state IDLE unconditionally.
- Latency: ack in the n-th BUSY cycle (n>=1) gives n+1 stall cycles. Data is valid in the DONE cycle. Minimum is 2 stall cycles.
- Acks received in IDLE or DONE are ignored.
- Reset:
  - State IDLE; all strobes, ext_sel, cpu_stall and cpu_err are 0.
  - Hold register, ext_addr and ext_wdata are 0.
  - Reset mid-BUSY aborts the transaction at that edge with no error pulse.
- cpu_rdata: outside DONE it holds the last captured value (0 after reset), except in the unmapped-read cycle, where it is 0.

Optional Feature:
- Macro: DMEM_BUS_TIMEOUT_EN.
- Enabled:
  - A wait counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When the counter reaches TIMEOUT_CYC, go to ERR.
  - ERR: strobes 0, cpu_stall=0, cpu_err=1, cpu_rdata={DATA_W{1'b1}}, store dropped. Next state IDLE.
  - An ack in the same cycle as the counter reaching TIMEOUT_CYC wins and goes to DONE.
- Disabled: no counter and no ERR state; BUSY waits indefinitely.

Test Plan:
- Internal store: addr 0x0040, we=1, wdata 0x1234 -> dm_we=1 same cycle, cpu_stall=0, ext_sel=0.
- Channel 0 load: addr 0x1008, re=1; ack on 3rd BUSY cycle with ext_rdata[15:0]=0xBEEF -> stall for 4 cycles, ext_sel=4'b0001, ext_addr=0x1008; DONE cycle shows cpu_rdata=0xBEEF, stall=0; no second transaction.
- Channel 3 store with ack on 1st BUSY cycle, plus ext_ack[1] asserted earlier -> early ack ignored, 2 stall cycles, ext_we=1, ext_wdata=0x00A5, ext_sel=4'b1000.
- Unmapped addr 0xF000 load -> cpu_err pulse, cpu_stall=0, cpu_rdata=0.
- rst asserted in 2nd BUSY cycle -> next edge: IDLE, ext_re=0, ext_sel=0, cpu_stall=0, no err.
- Timeout (DMEM_BUS_TIMEOUT_EN, TIMEOUT_CYC=15), channel 2 read, no ack -> 16 stall cycles, then ERR cycle with cpu_err=1, cpu_rdata=0xFFFF, stall=0; without the macro, stall stays high for 100 cycles.
